// File: rtl/bram_sdp_core.sv
// Simple-dual-port block RAM (write port A, read port B) with byte enables,
// selectable read-during-write policy and a clear sweep. Define BRAM_OUT_REG_EN for an extra output register.
module bram_sdp_core #(
    parameter int                        DATA_WIDTH  = 32,
    parameter int                        ADDR_WIDTH  = 8,
    parameter int                        RAM_DEPTH   = 1 << ADDR_WIDTH,
    parameter int                        BYTE_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0]     CLEAR_VALUE = '0,
    parameter int                        RDW_MODE    = 0
) (
    input  logic                               clka,
    input  logic                               rsta_n,
    input  logic                               ena,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   wea,
    input  logic [ADDR_WIDTH-1:0]              addra,
    input  logic [DATA_WIDTH-1:0]              dina,
    input  logic                               enb,
    input  logic [ADDR_WIDTH-1:0]              addrb,
    output logic [DATA_WIDTH-1:0]              doutb,
    output logic                               doutb_vld,
    input  logic                               clr_req,
    output logic                               init_busy,
    output logic                               init_done
);

    // state | meaning
    // CLEAR | sweeping CLEAR_VALUE through every word, ports ignored
    // READY | ports A and B live
    localparam int                    NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = ADDR_WIDTH'(1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
    logic                    init_done_nxt;

    logic [DATA_WIDTH-1:0]   mem [RAM_DEPTH];

    logic                    addra_ok, addrb_ok;
    logic                    wr_en, rd_en, collide;
    logic [DATA_WIDTH-1:0]   rd_old, rd_new, rd_word;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    vld_q;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state     <= CLEAR;
            clr_cnt   <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            init_done <= init_done_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clr_cnt_nxt   = clr_cnt;
        init_done_nxt = 1'b0;
        case (state)
            CLEAR: begin
                clr_cnt_nxt = clr_cnt + ONE_ADDR;
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt     = READY;
                    clr_cnt_nxt   = '0;
                    init_done_nxt = 1'b1;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = CLEAR;
        endcase
    end

    assign init_busy = (state == CLEAR);

    assign addra_ok = ({1'b0, addra} < DEPTH_W);
    assign addrb_ok = ({1'b0, addrb} < DEPTH_W);
    assign wr_en    = (state == READY) && ena && addra_ok;
    assign rd_en    = (state == READY) && enb;
    assign collide  = wr_en && (addra == addrb) && (|wea);

    // The array has no reset; the sweep is what makes its contents known.
    always_ff @(posedge clka) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= CLEAR_VALUE;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (wea[i]) mem[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    always_comb begin
        rd_old = addrb_ok ? mem[addrb] : CLEAR_VALUE;
        rd_new = rd_old;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (collide && wea[i]) rd_new[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        rd_word = (RDW_MODE == 1) ? rd_new : rd_old;
    end

    // Output stage runs regardless of state so a read issued with clr_req still completes.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= rd_en;
            if (rd_en) dout_q <= rd_word;
        end
    end

`ifdef BRAM_OUT_REG_EN
    logic [DATA_WIDTH-1:0]   dout_q2;
    logic                    vld_q2;

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            dout_q2 <= '0;
            vld_q2  <= 1'b0;
        end else begin
            dout_q2 <= dout_q;
            vld_q2  <= vld_q;
        end
    end

    assign doutb     = dout_q2;
    assign doutb_vld = vld_q2;
`else
    assign doutb     = dout_q;
    assign doutb_vld = vld_q;
`endif

endmodule

// File: doc/bram_sdp_core.md
# bram_sdp_core

Parametrised simple-dual-port block RAM with one write port (A) and one read port (B), per-byte write enables, and a selectable read-during-write policy. It replaces the fixed single-port IP instance in the coursework memory path. A built-in clear sequencer sweeps every word to a known value after reset or on request, so contents are deterministic without an init file.

## Interface
- DATA_WIDTH, 32, word width; must be a multiple of BYTE_WIDTH
- ADDR_WIDTH, 8, address width
- RAM_DEPTH, 1 << ADDR_WIDTH, words; must be ≤ 2^ADDR_WIDTH
- BYTE_WIDTH, 8, bits per write-enable lane; NUM_BYTES = DATA_WIDTH/BYTE_WIDTH
- CLEAR_VALUE, 0, word written by the clear sweep
- RDW_MODE, 0, same-address A-write/B-read collision: 0 = read-first (old data), 1 = write-first (new merged data)

Ports:
- clka  in  1  clock; all logic on rising edge
- rsta_n  in  1  asynchronous active-low reset
- ena  in  1  port A write strobe
- wea  in  NUM_BYTES  per-byte write enable; lane i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH]
- addra  in  ADDR_WIDTH  write address
- dina  in  DATA_WIDTH  write data
- enb  in  1  port B read strobe
- addrb  in  ADDR_WIDTH  read address
- doutb  out  DATA_WIDTH  read data
- doutb_vld  out  1  doutb holds a new read result this cycle
- clr_req  in  1  start a clear sweep (single-cycle pulse)
- init_busy  out  1  clear sweep in progress; ports A/B ignored
- init_done  out  1  one-cycle pulse when a sweep finishes

## Operation
- FSM states: CLEAR, READY.
- Reset (rsta_n low): state = CLEAR, clear counter = 0, init_busy = 1, init_done = 0, doutb = 0, doutb_vld = 0, read pipeline flushed. Memory array itself is not reset.
- CLEAR: each cycle writes CLEAR_VALUE to mem[counter], counter += 1. When counter == RAM_DEPTH-1 is written: next state READY, init_busy → 0, init_done = 1 for that one cycle. Sweep length exactly RAM_DEPTH cycles.
- In CLEAR: ena, enb, clr_req ignored; no new doutb_vld issued.
- READY: ena=1 writes lanes with wea[i]=1 at addra; unselected lanes keep old value; ena=1 with wea=0 is a no-op. enb=1 reads addrb.
- Collision (ena & enb, addra == addrb, any wea lane set): RDW_MODE 0 returns pre-write word; RDW_MODE 1 returns post-write merged word.
- clr_req in READY: that cycle's A/B operations still execute; CLEAR starts next cycle with counter = 0. Reads already in the pipeline complete normally.
- Address ≥ RAM_DEPTH: writes dropped; reads return CLEAR_VALUE.
- Reset mid-sweep restarts the sweep at address 0.

## Timing
- Read latency L = 1 (no macro): enb at edge n → doutb/doutb_vld at edge n+1.
- doutb_vld high exactly one cycle per accepted read; fully pipelined, one read per cycle.
- doutb holds last read value when doutb_vld = 0.
- Write visible to a B read issued the following cycle and later in all modes.
- First accepted access after reset: cycle RAM_DEPTH (init_done cycle is READY; ops that cycle accepted).

## Configuration
- BRAM_OUT_REG_EN defined: extra output register stage; L = 2; doutb/doutb_vld both delayed one cycle, reset to 0; collision semantics unchanged.
- Undefined: L = 1, single registered read.

## Test plan
- Reset, DATA_WIDTH=32, RAM_DEPTH=256, CLEAR_VALUE=0xA5A5A5A5 → init_busy high 256 cycles, init_done pulse once; read addr 0x00 and 0xFF → 0xA5A5A5A5 with doutb_vld after L cycles.
- Write 0x11223344 wea=4'b1111 at 0x10, then 0xAABBCCDD wea=4'b0101 at 0x10, read 0x10 → 0x11BB33DD.
- Same-cycle write 0xDEADBEEF / read at 0x20 holding 0: RDW_MODE 0 → 0x00000000; RDW_MODE 1 → 0xDEADBEEF.
- Back-to-back reads 0x00..0x07 with enb held 8 cycles → 8 consecutive doutb_vld pulses, data in order, starting L cycles after first enb.
- clr_req after writing 0x12345678 at 0x05, enb asserted during sweep → no doutb_vld while busy; after init_done read 0x05 → CLEAR_VALUE.
- rsta_n low at sweep cycle 100 for 2 cycles → outputs 0, init_busy stays 1, sweep restarts and lasts full 256 cycles after release.
